// File: rtl/sseg_scan_mux.sv
// Four-digit seven-segment scan multiplexer: a latched hex value is time-multiplexed
// across four common-anode digits, with dead-time and leading-zero blanking.
module sseg_scan_mux #(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  bin_out,
  output logic        dp_out,
  output logic [3:0]  an_out,
  output logic [1:0]  digit_idx
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYCLES);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   disp_val;
  logic [3:0]    disp_dp;

  function automatic logic [3:0] nib_sel(input logic [15:0] v, input logic [1:0] i);
    logic [3:0] n;
    case (i)
      2'd0:    n = v[3:0];
      2'd1:    n = v[7:4];
      2'd2:    n = v[11:8];
      2'd3:    n = v[15:12];
      default: n = 4'h0;
    endcase
    return n;
  endfunction

  // Digit 0 is never reported as a leading zero, so a zero value still shows "0".
  function automatic logic upper_zero(input logic [15:0] v, input logic [1:0] i);
    logic z;
    case (i)
      2'd1:    z = (v[15:4] == 12'h000);
      2'd2:    z = (v[15:8] == 8'h00);
      2'd3:    z = (v[15:12] == 4'h0);
      default: z = 1'b0;
    endcase
    return z;
  endfunction

  // Prescaler, digit pointer and display register; load and wrap may coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      idx      <= 2'd0;
      disp_val <= 16'h0000;
      disp_dp  <= 4'b0000;
    end else begin
      if (load) begin
        disp_val <= value_in;
        disp_dp  <= dp_in;
      end
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign digit_idx = idx;

  // Output decode straight from registered state; blank_lz acts in the same cycle.
  always_comb begin
    bin_out = nib_sel(disp_val, idx);
    dp_out  = ~disp_dp[idx];
    an_out  = 4'b1111;
    if (cnt < CNT_DEAD) begin
      an_out = 4'b1111;
    end else if (blank_lz && upper_zero(disp_val, idx) && !disp_dp[idx]) begin
      an_out = 4'b1111;
    end else begin
      an_out = ~(4'b0001 << idx);
    end
  end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Randomized bench for sseg_scan_mux with a cycle-count based reference model,
// plus directed scenarios pinned by literal expectations.
module tb_sseg_scan_mux;

  localparam int RDIV = 4;
  localparam int DEAD = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        blank_lz = 1'b0;
  logic [3:0]  bin_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic [1:0]  digit_idx;

  int checks = 0;
  int failures = 0;

  sseg_scan_mux #(.REFRESH_DIV(RDIV), .DEAD_CYCLES(DEAD)) dut (
    .clk(clk), .reset(reset), .load(load), .value_in(value_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .bin_out(bin_out), .dp_out(dp_out), .an_out(an_out),
    .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: everything follows from cycles elapsed since reset.
  int m_t = 0;
  int m_val = 0;
  int m_dp = 0;
  bit m_valid = 0;

  function automatic int m_idx(input int t);
    return (t / RDIV) % 4;
  endfunction

  function automatic int m_an(input int t, input int val, input int dp, input bit bl);
    int i;
    i = m_idx(t);
    if ((t % RDIV) < DEAD) return 15;
    if (i != 0 && bl && (val >> (4 * i)) == 0 && ((dp >> i) & 1) == 0) return 15;
    return 15 ^ (1 << i);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_t = 0; m_val = 0; m_dp = 0; m_valid = 1;
    end else begin
      if (load) begin
        m_val = int'(value_in);
        m_dp  = int'(dp_in);
      end
      m_t++;
    end
    #1;
    if (m_valid) begin
      chk("model_idx", 32'(digit_idx), 32'(m_idx(m_t)));
      chk("model_bin", 32'(bin_out), 32'((m_val >> (4 * m_idx(m_t))) & 15));
      chk("model_dp", 32'(dp_out), 32'(1 - ((m_dp >> m_idx(m_t)) & 1)));
      chk("model_an", 32'(an_out), 32'(m_an(m_t, m_val, m_dp, blank_lz)));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset for one edge, release with an optional load; returns at t=1 with load low.
  task automatic start_scan(input logic do_load, input logic [15:0] v, input logic [3:0] d);
    reset = 1'b1; load = 1'b0;
    tick(1);
    reset = 1'b0; load = do_load; value_in = v; dp_in = d;
    tick(1);
    load = 1'b0;
  endtask

  logic [3:0] exp_bin [4];
  logic [15:0] mask;

  initial begin
    // Reset state and first scan steps
    tick(1);
    chk("rst_an", 32'(an_out), 32'(4'b1111));
    chk("rst_bin", 32'(bin_out), 32'(4'h0));
    chk("rst_dp", 32'(dp_out), 32'(1'b1));
    chk("rst_idx", 32'(digit_idx), 32'(2'd0));
    reset = 1'b0;
    tick(4);
    chk("scan_t4_an", 32'(an_out), 32'(4'b1111));
    chk("scan_t4_idx", 32'(digit_idx), 32'(2'd1));
    tick(1);
    chk("scan_t5_an", 32'(an_out), 32'(4'b1101));

    // 12AF with point on digit 2
    exp_bin = '{4'hF, 4'hA, 4'h2, 4'h1};
    start_scan(1'b1, 16'h12AF, 4'b0100);
    chk("load_next_cycle", 32'(bin_out), 32'(4'hF));
    tick(1);
    for (int s = 0; s < 4; s++) begin
      chk("hex_bin", 32'(bin_out), 32'(exp_bin[s]));
      chk("hex_dp", 32'(dp_out), 32'((s == 2) ? 1'b0 : 1'b1));
      tick(4);
    end

    // 0005 with blanking, then blanking disabled
    blank_lz = 1'b1;
    start_scan(1'b1, 16'h0005, 4'b0000);
    for (int s = 0; s < 4; s++) begin
      chk("lz_on_an", 32'(an_out), 32'((s == 0) ? 4'b1110 : 4'b1111));
      tick(4);
    end
    blank_lz = 1'b0;
    chk("lz_off_an0", 32'(an_out), 32'(4'b1110));
    for (int s = 1; s <= 4; s++) begin
      tick(4);
      chk("lz_off_an", 32'(an_out), 32'(4'hF ^ (4'b0001 << (s % 4))));
    end

    // Zero value with point on digit 1
    blank_lz = 1'b1;
    start_scan(1'b1, 16'h0000, 4'b0010);
    chk("zero_an0", 32'(an_out), 32'(4'b1110));
    chk("zero_bin0", 32'(bin_out), 32'(4'h0));
    tick(4);
    chk("zero_an1", 32'(an_out), 32'(4'b1101));
    chk("zero_dp1", 32'(dp_out), 32'(1'b0));
    tick(4);
    chk("zero_an2", 32'(an_out), 32'(4'b1111));
    tick(4);
    chk("zero_an3", 32'(an_out), 32'(4'b1111));
    blank_lz = 1'b0;

    // Load coinciding with the slot 1 -> 2 wrap
    start_scan(1'b0, 16'h0000, 4'b0000);
    tick(6);
    load = 1'b1; value_in = 16'h7700;
    tick(1);
    load = 1'b0;
    chk("wrapload_idx", 32'(digit_idx), 32'(2'd2));
    chk("wrapload_bin", 32'(bin_out), 32'(4'h7));
    chk("wrapload_an_dead", 32'(an_out), 32'(4'b1111));
    tick(1);
    chk("wrapload_an", 32'(an_out), 32'(4'b1011));

    // Reset mid-slot 3
    start_scan(1'b1, 16'hBEEF, 4'hF);
    tick(13);
    chk("midrst_pre_idx", 32'(digit_idx), 32'(2'd3));
    chk("midrst_pre_bin", 32'(bin_out), 32'(4'hB));
    reset = 1'b1;
    tick(1);
    chk("midrst_idx", 32'(digit_idx), 32'(2'd0));
    chk("midrst_an", 32'(an_out), 32'(4'b1111));
    chk("midrst_bin", 32'(bin_out), 32'(4'h0));
    chk("midrst_dp", 32'(dp_out), 32'(1'b1));
    reset = 1'b0;
    tick(5);
    chk("midrst_resume_idx", 32'(digit_idx), 32'(2'd1));
    chk("midrst_resume_an", 32'(an_out), 32'(4'b1101));

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0: mask = 16'h000F;
        1: mask = 16'h00FF;
        2: mask = 16'h0FFF;
        default: mask = 16'hFFFF;
      endcase
      reset    = ($urandom_range(0, 299) == 0);
      load     = ($urandom_range(0, 3) == 0);
      value_in = 16'($urandom) & mask;
      dp_in    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      blank_lz = ($urandom_range(0, 3) != 0);
      tick(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
